// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with redirect target adder, valid/ready fetch handshake and misalignment trap FSM
//
// Optional feature: define C_EXT_EN for compressed (16-bit) instruction support.
//
// Parameters:
//    XLEN       PC / operand width
//    RESET_VEC  PC loaded by reset
//    TRAP_VEC   PC loaded on trap acknowledge
//    CNT_W      width of the saturating redirect counter
//
// Ports:
//    clk, rst            clock (rising edge), asynchronous active-high reset
//    BusA, Imm, br_pc    target adder operands
//    NxtASrc, NxtBSrc    operand selects (A: BusA/br_pc, B: Imm/step)
//    br_c, fetch_c       16-bit flags for redirect source and current fetch (C_EXT_EN only)
//    redirect, stall     load target / hold PC
//    if_ready            fetch accepts pc_out
//    trap_ack            leave HALT and resume at TRAP_VEC
//    pc_out, pc_valid    fetch address and its valid flag
//    misalign            high while halted on a misaligned redirect
//    epc, bad_addr       br_pc and target of the faulting redirect
//    redir_cnt           saturating count of accepted redirects
module pc_unit #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h100),
   parameter int              CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  BusA,
   input  logic [XLEN-1:0]  Imm,
   input  logic [XLEN-1:0]  br_pc,
   input  logic             NxtASrc,
   input  logic             NxtBSrc,
   input  logic             br_c,
   input  logic             fetch_c,
   input  logic             redirect,
   input  logic             stall,
   input  logic             if_ready,
   output logic [XLEN-1:0]  pc_out,
   output logic             pc_valid,
   output logic             misalign,
   output logic [XLEN-1:0]  epc,
   output logic [XLEN-1:0]  bad_addr,
   input  logic             trap_ack,
   output logic [CNT_W-1:0] redir_cnt
);
   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
   state_t           state_q;
   logic [XLEN-1:0]  pc_q, epc_q, bad_q;
   logic [CNT_W-1:0] cnt_q;
   logic             valid_q, mis_q;
   logic [XLEN-1:0]  op_a, op_b, step, step_b, tgt_d, seq_d;
   logic             bad_d;
   assign op_a  = NxtASrc ? BusA : br_pc;
   assign op_b  = NxtBSrc ? Imm : step_b;
   assign tgt_d = (op_a + op_b) & ~XLEN'(1);
   assign seq_d = pc_q + step;
`ifdef C_EXT_EN
   assign step   = fetch_c ? XLEN'(2) : XLEN'(4);
   assign step_b = br_c ? XLEN'(2) : XLEN'(4);
   // halfword alignment is always satisfied once bit 0 is cleared
   assign bad_d  = 1'b0;
`else
   logic unused_c;
   assign unused_c = fetch_c ^ br_c;
   assign step     = XLEN'(4);
   assign step_b   = XLEN'(4);
   assign bad_d    = tgt_d[1];
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_VEC;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         epc_q   <= '0;
         bad_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
            end
            RUN: begin
               // redirect wins over stall and discards any un-accepted fetch
               if (redirect && bad_d) begin
                  state_q <= HALT;
                  valid_q <= 1'b0;
                  mis_q   <= 1'b1;
                  epc_q   <= br_pc;
                  bad_q   <= tgt_d;
               end else if (redirect) begin
                  pc_q <= tgt_d;
                  if (~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
               end else if (!stall && if_ready) begin
                  pc_q <= seq_d;
               end
            end
            HALT: begin
               if (trap_ack) begin
                  state_q <= RUN;
                  pc_q    <= TRAP_VEC;
                  valid_q <= 1'b1;
                  mis_q   <= 1'b0;
               end
            end
            default: state_q <= BOOT;
         endcase
      end
   end
   assign pc_out    = pc_q;
   assign pc_valid  = valid_q;
   assign misalign  = mis_q;
   assign epc       = epc_q;
   assign bad_addr  = bad_q;
   assign redir_cnt = cnt_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (default and CNT_W=2 instances)
module tb_pc_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] BusA, Imm, br_pc;
   logic        NxtASrc, NxtBSrc, br_c, fetch_c, redirect, stall, if_ready, trap_ack;
   logic [31:0] pc_out, epc, bad_addr, s_pc, s_epc, s_bad;
   logic        pc_valid, misalign, s_valid, s_mis;
   logic [15:0] redir_cnt;
   logic [1:0]  s_cnt;
   int          n_chk = 0;
   int          n_pass = 0;
   int          exp_cnt = 0;

   always #5 clk = ~clk;

   pc_unit u_dut (
      .clk(clk), .rst(rst), .BusA(BusA), .Imm(Imm), .br_pc(br_pc),
      .NxtASrc(NxtASrc), .NxtBSrc(NxtBSrc), .br_c(br_c), .fetch_c(fetch_c),
      .redirect(redirect), .stall(stall), .if_ready(if_ready),
      .pc_out(pc_out), .pc_valid(pc_valid), .misalign(misalign),
      .epc(epc), .bad_addr(bad_addr), .trap_ack(trap_ack), .redir_cnt(redir_cnt)
   );

   pc_unit #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .BusA(BusA), .Imm(Imm), .br_pc(br_pc),
      .NxtASrc(NxtASrc), .NxtBSrc(NxtBSrc), .br_c(br_c), .fetch_c(fetch_c),
      .redirect(redirect), .stall(stall), .if_ready(if_ready),
      .pc_out(s_pc), .pc_valid(s_valid), .misalign(s_mis),
      .epc(s_epc), .bad_addr(s_bad), .trap_ack(trap_ack), .redir_cnt(s_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
      else n_pass++;
   endtask

   task automatic cyc;
      @(negedge clk);
   endtask

   task automatic redir(input logic a, input logic b, input logic [31:0] bus, input logic [31:0] imm, input logic [31:0] bpc);
      NxtASrc = a; NxtBSrc = b; BusA = bus; Imm = imm; br_pc = bpc; redirect = 1'b1;
      cyc();
      redirect = 1'b0;
   endtask

   initial begin
      rst = 1'b1; BusA = '0; Imm = '0; br_pc = '0; NxtASrc = 1'b0; NxtBSrc = 1'b0;
      br_c = 1'b0; fetch_c = 1'b0; redirect = 1'b0; stall = 1'b0; if_ready = 1'b1; trap_ack = 1'b0;
      #2;
      check("rst_pc", pc_out, 32'h0);
      check("rst_valid", {31'b0, pc_valid}, 32'h0);
      check("rst_mis", {31'b0, misalign}, 32'h0);
      check("rst_epc", epc, 32'h0);
      check("rst_bad", bad_addr, 32'h0);
      check("rst_cnt", {16'b0, redir_cnt}, 32'h0);
      cyc();
      rst = 1'b0;
      check("boot_valid", {31'b0, pc_valid}, 32'h0);
      cyc();
      check("run_valid", {31'b0, pc_valid}, 32'h1);
      check("seq0", pc_out, 32'h0);
      cyc(); check("seq4", pc_out, 32'h4);
      cyc(); check("seq8", pc_out, 32'h8);
      cyc(); check("seqC", pc_out, 32'hC);
      check("seq_cnt", {16'b0, redir_cnt}, 32'h0);
      // jalr together with stall: redirect wins
      stall = 1'b1;
      redir(1'b1, 1'b1, 32'h1001, 32'h10, 32'h0);
      stall = 1'b0; exp_cnt++;
      check("jalr_pc", pc_out, 32'h1010);
      check("jalr_cnt", {16'b0, redir_cnt}, 32'h1);
      redir(1'b0, 1'b1, 32'h0, 32'h10, 32'h10);
      exp_cnt++;
      check("br20_pc", pc_out, 32'h20);
      check("sat_cnt2", {30'b0, s_cnt}, 32'h2);
      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(); check("bp_hold", pc_out, 32'h20);
      end
      if_ready = 1'b1;
      cyc(); check("bp_release", pc_out, 32'h24);
      stall = 1'b1;
      cyc(); check("stall_hold", pc_out, 32'h24);
      stall = 1'b0;
      cyc(); check("stall_release", pc_out, 32'h28);
`ifdef C_EXT_EN
      if_ready = 1'b0;
      redir(1'b0, 1'b1, 32'h0, 32'h22, 32'h40);
      exp_cnt++;
      check("c_br_pc", pc_out, 32'h62);
      check("c_br_mis", {31'b0, misalign}, 32'h0);
      check("c_br_valid", {31'b0, pc_valid}, 32'h1);
      if_ready = 1'b1; fetch_c = 1'b1;
      cyc(); check("c_step2", pc_out, 32'h64);
      fetch_c = 1'b0;
      cyc(); check("c_step4", pc_out, 32'h68);
      br_c = 1'b1;
      redir(1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
      br_c = 1'b0; exp_cnt++;
      check("c_seqb2", pc_out, 32'h102);
`else
      redir(1'b0, 1'b1, 32'h0, 32'h22, 32'h40);
      check("halt_valid", {31'b0, pc_valid}, 32'h0);
      check("halt_mis", {31'b0, misalign}, 32'h1);
      check("halt_epc", epc, 32'h40);
      check("halt_bad", bad_addr, 32'h62);
      check("halt_pc", pc_out, 32'h28);
      stall = 1'b1;
      redir(1'b0, 1'b1, 32'h0, 32'h0, 32'h80);
      stall = 1'b0;
      check("halt_ign_pc", pc_out, 32'h28);
      check("halt_ign_cnt", {16'b0, redir_cnt}, 32'h2);
      check("halt_ign_mis", {31'b0, misalign}, 32'h1);
      trap_ack = 1'b1;
      cyc();
      trap_ack = 1'b0;
      check("trap_pc", pc_out, 32'h100);
      check("trap_valid", {31'b0, pc_valid}, 32'h1);
      check("trap_mis", {31'b0, misalign}, 32'h0);
      check("trap_epc", epc, 32'h40);
      check("trap_bad", bad_addr, 32'h62);
`endif
      redir(1'b0, 1'b0, 32'h0, 32'h0, 32'h200);
      exp_cnt++;
      check("seqb_pc", pc_out, 32'h204);
      redir(1'b1, 1'b1, 32'hFFFF_FFF0, 32'hC, 32'h0);
      exp_cnt++;
      check("wrap_pre", pc_out, 32'hFFFF_FFFC);
      cyc(); check("wrap_zero", pc_out, 32'h0);
      redir(1'b1, 1'b1, 32'h300, 32'h0, 32'h0);
      exp_cnt++;
      check("last_pc", pc_out, 32'h300);
      check("cnt_total", {16'b0, redir_cnt}, exp_cnt);
      check("sat_cnt3", {30'b0, s_cnt}, 32'h3);
`ifndef C_EXT_EN
      if_ready = 1'b0;
      redir(1'b0, 1'b1, 32'h0, 32'h22, 32'h40);
      check("halt2_mis", {31'b0, misalign}, 32'h1);
`endif
      #1 rst = 1'b1;
      #1;
      check("arst_mis", {31'b0, misalign}, 32'h0);
      check("arst_pc", pc_out, 32'h0);
      check("arst_valid", {31'b0, pc_valid}, 32'h0);
      check("arst_epc", epc, 32'h0);
      check("arst_cnt", {16'b0, redir_cnt}, 32'h0);
      check("arst_sat", {30'b0, s_cnt}, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: the successor of our combinational next-PC adder. It holds the fetch PC in a register and drives it to instruction fetch through a valid/ready handshake. It takes redirects from the execute stage using the same NxtASrc/NxtBSrc operand selection as before, and traps on misaligned targets through a small state machine. It sits between the execute-stage branch logic and the instruction-fetch port.

## Interface
- XLEN, 32: PC and operand width (≥16).
- RESET_VEC, 0: PC loaded on reset (XLEN bits).
- TRAP_VEC, 'h100: PC loaded on trap acknowledge (XLEN bits).
- CNT_W, 16: redirect counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- BusA  in  XLEN  register operand (jalr base).
- Imm  in  XLEN  immediate offset.
- br_pc  in  XLEN  PC of the resolving branch/jump.
- NxtASrc  in  1  adder A select: 1 = BusA, 0 = br_pc.
- NxtBSrc  in  1  adder B select: 1 = Imm, 0 = sequential step.
- br_c  in  1  resolving instruction is 16-bit (used only with C_EXT_EN).
- fetch_c  in  1  instruction at pc_out is 16-bit (used only with C_EXT_EN).
- redirect  in  1  load computed target this cycle.
- stall  in  1  hold PC.
- if_ready  in  1  fetch accepts pc_out.
- pc_out  out  XLEN  current fetch PC.
- pc_valid  out  1  pc_out is valid for fetch.
- misalign  out  1  high while in HALT.
- epc  out  XLEN  br_pc of the faulting redirect.
- bad_addr  out  XLEN  faulting target.
- trap_ack  in  1  leave HALT and go to TRAP_VEC.
- redir_cnt  out  CNT_W  saturating count of accepted redirects.

## Operation
- Target computation:
  - A = NxtASrc ? BusA : br_pc.
  - B = NxtBSrc ? Imm : step_b.
  - target = (A + B) mod 2^XLEN, with bit 0 forced to 0.
- Sequential step: step = 4 and step_b = 4, unless C_EXT_EN is defined.
- FSM states:
  - BOOT: entered on reset. pc_out = RESET_VEC, pc_valid = 0. Moves to RUN after one clock.
  - RUN: pc_valid = 1.
  - HALT: pc_valid = 0, misalign = 1. Ignores redirect and stall. On trap_ack: pc_out ← TRAP_VEC and go to RUN. epc and bad_addr hold their values.
- RUN priority, highest first:
  1. redirect with misaligned target: go to HALT, epc ← br_pc, bad_addr ← target, pc_out unchanged.
  2. redirect: pc_out ← target, redir_cnt += 1 (saturates at all-ones).
  3. stall: hold pc_out.
  4. if_ready: pc_out ← pc_out + step.
  5. otherwise: hold pc_out.
- Misaligned means target[1] = 1 when C_EXT_EN is not defined. With C_EXT_EN defined, a target is never misaligned.
- A redirect overrides both stall and a pending fetch handshake. The un-accepted pc_out is discarded.
- Adder wrap-around is silent: 'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (asynchronous, immediate): pc_out = RESET_VEC, pc_valid = 0, misalign = 0, epc = 0, bad_addr = 0, redir_cnt = 0, state = BOOT.
- First valid fetch: pc_valid rises on the first rising edge after rst deasserts.
- Redirect latency: 1 cycle. The target appears on pc_out at the edge that samples redirect.
- HALT entry: pc_valid falls and misalign rises at the edge that samples the bad redirect.
- HALT exit: on the edge sampling trap_ack, pc_out = TRAP_VEC, pc_valid = 1, misalign = 0.
- Handshake: an address is transferred on an edge where pc_valid & if_ready & ~stall & ~redirect. pc_out is stable while pc_valid & ~if_ready and no redirect is present.
- Reset asserted mid-operation: all state returns to the reset values asynchronously. A trap in progress is abandoned.
- Target, epc and bad_addr are registered. There is no combinational path from any input to pc_out.

## Configuration
- C_EXT_EN defined (compressed instructions):
  - step = fetch_c ? 2 : 4.
  - step_b = br_c ? 2 : 4.
  - Targets only need 2-byte alignment, so HALT is unreachable from a redirect.
- C_EXT_EN undefined:
  - fetch_c and br_c are ignored.
  - step = step_b = 4.
  - target[1] = 1 traps.

## Test plan
- Reset then run, if_ready = 1: pc_valid = 0 in the first cycle; pc_out then follows 0, 4, 8, 'hC; redir_cnt = 0.
- jalr, with NxtASrc = 1, NxtBSrc = 1, BusA = 'h1001, Imm = 'h10, redirect asserted at the same time as stall = 1: next pc_out = 'h1010; redir_cnt = 1.
- Branch, with br_pc = 'h40, Imm = 'h22, NxtASrc = 0, NxtBSrc = 1, redirect, C_EXT_EN undefined: go to HALT; epc = 'h40, bad_addr = 'h62, pc_valid = 0. Then trap_ack gives pc_out = 'h100, pc_valid = 1.
- Same branch with C_EXT_EN defined: pc_out = 'h62, no trap. Then fetch_c = 1 gives 'h64, fetch_c = 0 gives 'h68.
- Backpressure: if_ready = 0 for 3 cycles holds pc_out at 'h20. Then 'h24 on the first cycle with if_ready = 1.
- Wrap and saturation:
  - pc 'hFFFF_FFFC advances to 0.
  - With CNT_W = 2, 5 redirects give redir_cnt = 3.
  - rst asserted while in HALT clears misalign immediately.
